// File: rtl/ucsbece154a_controller_mw.sv
// Multicycle RV32I control unit with memory-ready wait states, extended ALU decode
// and a sticky illegal-opcode trap. Moore controls are registered from next-state decode.
module ucsbece154a_controller_mw #(
  parameter int ALUCTRL_W   = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 PCWrite_o,
  output logic                 IRWrite_o,
  output logic                 MemWrite_o,
  output logic                 RegWrite_o,
  output logic                 AdrSrc_o,
  output logic [1:0]           ALUSrcA_o,
  output logic [1:0]           ALUSrcB_o,
  output logic [1:0]           ResultSrc_o,
  output logic [ALUCTRL_W-1:0] ALUControl_o,
  output logic [2:0]           ImmSrc_o,
  output logic                 illegal_o
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR, S_JALRJUMP,
    S_LUI, S_ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
    ALU_SRA  = 4'd8, ALU_SLTU = 4'd9
  } alu_t;

  typedef struct packed {
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    alu_t       alu;
    logic       mw;
    logic       rw;
    logic       ill;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{adr: 1'b0, srca: 2'b00, srcb: 2'b10, res: 2'b10,
                                   alu: ALU_ADD, mw: 1'b0, rw: 1'b0, ill: 1'b0};

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  alu_t   alu_op;
  logic   ready;
  logic   br_ok;

  assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  assign br_ok = (funct3_i == 3'b000) || (funct3_i == 3'b001);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_op = ((op_i == OP_R) && funct7_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALRADR;
          OP_LUI:       state_d = S_LUI;
          OP_AUIPC:     state_d = S_ALUWB;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = br_ok ? S_FETCH : S_ILLEGAL;
      S_JAL:      state_d = S_ALUWB;
      S_JALRADR:  state_d = S_JALRJUMP;
      S_JALRJUMP: state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Controls are decoded from the state being entered so they are aligned with it.
  always_comb begin
    ctrl_d     = '0;
    ctrl_d.alu = ALU_ADD;
    case (state_d)
      S_FETCH:    ctrl_d = CTRL_FETCH;
      S_DECODE:   begin ctrl_d.srca = 2'b01; ctrl_d.srcb = 2'b01; end
      S_MEMADR:   begin ctrl_d.srca = 2'b10; ctrl_d.srcb = 2'b01; end
      S_MEMREAD:  ctrl_d.adr = 1'b1;
      S_MEMWB:    begin ctrl_d.rw = 1'b1; ctrl_d.res = 2'b01; end
      S_MEMWRITE: begin ctrl_d.adr = 1'b1; ctrl_d.mw = 1'b1; end
      S_EXECR:    begin ctrl_d.srca = 2'b10; ctrl_d.srcb = 2'b00; ctrl_d.alu = alu_op; end
      S_EXECI:    begin ctrl_d.srca = 2'b10; ctrl_d.srcb = 2'b01; ctrl_d.alu = alu_op; end
      S_ALUWB:    ctrl_d.rw = 1'b1;
      S_BRANCH:   begin ctrl_d.srca = 2'b10; ctrl_d.srcb = 2'b00; ctrl_d.alu = ALU_SUB; end
      S_JAL:      begin ctrl_d.srca = 2'b01; ctrl_d.srcb = 2'b10; end
      S_JALRADR:  begin ctrl_d.srca = 2'b10; ctrl_d.srcb = 2'b01; end
      S_JALRJUMP: begin ctrl_d.srca = 2'b01; ctrl_d.srcb = 2'b10; end
      S_LUI:      begin ctrl_d.rw = 1'b1; ctrl_d.res = 2'b11; end
      S_ILLEGAL:  ctrl_d.ill = 1'b1;
      default:    ctrl_d = CTRL_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    PCWrite_o = 1'b0;
    case (state_q)
      S_FETCH:    PCWrite_o = ready;
      S_BRANCH: begin
        if (funct3_i == 3'b000)      PCWrite_o = zero_i;
        else if (funct3_i == 3'b001) PCWrite_o = ~zero_i;
        else                         PCWrite_o = 1'b0;
      end
      S_JAL:      PCWrite_o = 1'b1;
      S_JALRJUMP: PCWrite_o = 1'b1;
      default:    PCWrite_o = 1'b0;
    endcase
    PCWrite_o = PCWrite_o & ~reset;
  end

  assign IRWrite_o  = (state_q == S_FETCH) & ready & ~reset;
  assign MemWrite_o = ctrl_q.mw & ~reset;
  assign RegWrite_o = ctrl_q.rw & ~reset;

  assign AdrSrc_o     = ctrl_q.adr;
  assign ALUSrcA_o    = ctrl_q.srca;
  assign ALUSrcB_o    = ctrl_q.srcb;
  assign ResultSrc_o  = ctrl_q.res;
  assign ALUControl_o = ALUCTRL_W'(ctrl_q.alu);
  assign illegal_o    = ctrl_q.ill;

  always_comb begin
    ImmSrc_o = 3'b000;
    case (op_i)
      OP_SW:            ImmSrc_o = 3'b001;
      OP_BR:            ImmSrc_o = 3'b010;
      OP_JAL:           ImmSrc_o = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc_o = 3'b100;
      default:          ImmSrc_o = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_ucsbece154a_controller_mw.sv
// Randomised instruction-stream bench: each instruction expands into its expected
// per-cycle step list, and every cycle's outputs are compared with that step's controls.
module tb_ucsbece154a_controller_mw;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum int {
    FETCH, DECODE, ADDR, MEMRD, MEMWB, MEMWR, EXR, EXI, WB, BR, JAL, JADR, JJMP, LUI, ILL
  } step_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op_i = '0;
  logic [2:0] funct3_i = '0;
  logic       funct7_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       PCWrite_o, IRWrite_o, MemWrite_o, RegWrite_o, AdrSrc_o, illegal_o;
  logic [1:0] ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
  logic [4:0] ALUControl_o;
  logic [2:0] ImmSrc_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  always #5 clk = ~clk;

  ucsbece154a_controller_mw #(.ALUCTRL_W(5), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o),
    .IRWrite_o(IRWrite_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .AdrSrc_o(AdrSrc_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ResultSrc_o(ResultSrc_o), .ALUControl_o(ALUControl_o), .ImmSrc_o(ImmSrc_o),
    .illegal_o(illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  function automatic logic [4:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 5'd1 : 5'd0;
      3'd1: return 5'd6;
      3'd2: return 5'd5;
      3'd3: return 5'd9;
      3'd4: return 5'd4;
      3'd5: return f7 ? 5'd8 : 5'd7;
      3'd6: return 5'd3;
      default: return 5'd2;
    endcase
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] op);
    if (op == OP_SW) return 3'b001;
    if (op == OP_BR) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  // {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, SrcA, SrcB, ResultSrc, ALUControl, illegal, ImmSrc}
  function automatic logic [19:0] exp_vec(input step_e s, input bit r, input bit z);
    logic pcw = 1'b0, irw = 1'b0, mw = 1'b0, rw = 1'b0, adr = 1'b0, ill = 1'b0;
    logic [1:0] a = 2'b00, b = 2'b00, rs = 2'b00;
    logic [4:0] alu = 5'd0;
    case (s)
      FETCH:  begin pcw = r; irw = r; b = 2'b10; rs = 2'b10; end
      DECODE: begin a = 2'b01; b = 2'b01; end
      ADDR:   begin a = 2'b10; b = 2'b01; end
      MEMRD:  adr = 1'b1;
      MEMWB:  begin rw = 1'b1; rs = 2'b01; end
      MEMWR:  begin adr = 1'b1; mw = 1'b1; end
      EXR:    begin a = 2'b10; alu = alu_ref(1'b1, cur_f3, cur_f7); end
      EXI:    begin a = 2'b10; b = 2'b01; alu = alu_ref(1'b0, cur_f3, cur_f7); end
      WB:     rw = 1'b1;
      BR: begin
        a = 2'b10; alu = 5'd1;
        pcw = (cur_f3 == 3'd0) ? z : (cur_f3 == 3'd1) ? ~z : 1'b0;
      end
      JAL:    begin pcw = 1'b1; a = 2'b01; b = 2'b10; end
      JADR:   begin a = 2'b10; b = 2'b01; end
      JJMP:   begin pcw = 1'b1; a = 2'b01; b = 2'b10; end
      LUI:    begin rw = 1'b1; rs = 2'b11; end
      default: ill = 1'b1;
    endcase
    return {pcw, irw, mw, rw, adr, a, b, rs, alu, ill, imm_ref(cur_op)};
  endfunction

  task automatic do_step(input step_e s, input bit rdy, input bit z);
    mem_ready_i = rdy;
    zero_i = z;
    #1;
    check(s.name(), {12'd0, PCWrite_o, IRWrite_o, MemWrite_o, RegWrite_o, AdrSrc_o,
                     ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ALUControl_o, illegal_o, ImmSrc_o},
          {12'd0, exp_vec(s, rdy, z)});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    check("reset_enables", {28'd0, PCWrite_o, IRWrite_o, MemWrite_o, RegWrite_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // wt < 0: random ready everywhere; wt >= 0: fetch ready, data accesses wait wt cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int wt, input int zv);
    step_e q[$];
    q = '{FETCH, DECODE};
    case (op)
      OP_LW:    q = {q, ADDR, MEMRD, MEMWB};
      OP_SW:    q = {q, ADDR, MEMWR};
      OP_R:     q = {q, EXR, WB};
      OP_I:     q = {q, EXI, WB};
      OP_BR:    q.push_back(BR);
      OP_JAL:   q = {q, JAL, WB};
      OP_JALR:  q = {q, JADR, JJMP, WB};
      OP_LUI:   q.push_back(LUI);
      OP_AUIPC: q.push_back(WB);
      default:  ;
    endcase
    if (!(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}) ||
        (op == OP_BR && f3 > 3'd1))
      for (int i = 0; i < 10; i++) q.push_back(ILL);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    op_i = op; funct3_i = f3; funct7_i = f7;
    foreach (q[k]) begin
      bit z;
      z = (zv == 2) ? 1'($urandom % 2) : 1'(zv);
      if (q[k] inside {FETCH, MEMRD, MEMWR}) begin
        int  waits = 0;
        bit  done  = 1'b0;
        while (!done) begin
          bit rdy;
          if (wt >= 0) rdy = (q[k] == FETCH) ? 1'b1 : (waits >= wt);
          else         rdy = (waits >= 6) || ($urandom % 3 != 0);
          do_step(q[k], rdy, z);
          done = rdy;
          waits++;
        end
      end else begin
        do_step(q[k], 1'($urandom % 2), z);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[9];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    repeat (2) @(negedge clk);
    do_reset();

    run_instr(OP_LW, 3'd2, 1'b0, 0, 0);
    run_instr(OP_SW, 3'd2, 1'b0, 3, 0);
    run_instr(OP_R, 3'd5, 1'b1, 0, 0);
    run_instr(OP_I, 3'd5, 1'b1, 0, 0);
    run_instr(OP_I, 3'd0, 1'b1, 0, 0);
    run_instr(OP_R, 3'd0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'd1, 1'b0, 0, 0);
    run_instr(OP_BR, 3'd0, 1'b0, 0, 0);
    run_instr(OP_BR, 3'd0, 1'b0, 0, 1);
    run_instr(OP_JALR, 3'd0, 1'b0, 0, 0);
    run_instr(OP_JAL, 3'd0, 1'b0, 0, 0);
    run_instr(OP_LUI, 3'd0, 1'b0, 0, 0);
    run_instr(OP_AUIPC, 3'd0, 1'b0, 0, 0);

    run_instr(7'b0000000, 3'd0, 1'b0, 0, 0);
    do_reset();
    run_instr(OP_BR, 3'd2, 1'b0, 0, 0);
    do_reset();

    // Abort a store mid-access with reset.
    cur_op = OP_SW; cur_f3 = 3'd2; cur_f7 = 1'b0;
    op_i = OP_SW; funct3_i = 3'd2; funct7_i = 1'b0;
    do_step(FETCH, 1'b1, 1'b0);
    do_step(DECODE, 1'b1, 1'b0);
    do_step(ADDR, 1'b1, 1'b0);
    do_step(MEMWR, 1'b0, 1'b0);
    do_reset();
    run_instr(OP_SW, 3'd2, 1'b0, 1, 0);

    for (int n = 0; n < 200; n++) begin
      int sel;
      logic [2:0] f3;
      sel = $urandom_range(0, 8);
      f3  = 3'($urandom);
      if (ops[sel] == OP_BR) f3 = 3'($urandom % 2);
      run_instr(ops[sel], f3, 1'($urandom % 2), -1, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_controller_mw.md
Name: ucsbece154a_controller_mw

Overview:
Parametrised multicycle RV32I control unit: the next generation of the team's multicycle controller. Adds a memory-ready handshake with wait states, a wider ALU-control field (xor, shifts, sltu), bne, jalr, auipc, and a sticky illegal-opcode trap. It drives the existing multicycle datapath (PC, IR, OldPC, ALUOut, Data registers) and the unified instruction/data memory.

Parameters:
ALUCTRL_W, 4, ALUControl_o width; must be 4 or more, upper bits zero-extended.
MEM_WAIT_EN, 1, 1 = honour mem_ready_i; 0 = treat mem_ready_i as constant 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_i  in  7  instruction opcode
funct3_i  in  3  instruction funct3
funct7_i  in  1  instruction bit 30
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory access completes this cycle
PCWrite_o  out  1  PC load enable (combinational)
IRWrite_o  out  1  IR/OldPC load enable (combinational)
MemWrite_o  out  1  memory write strobe
RegWrite_o  out  1  register-file write enable
AdrSrc_o  out  1  memory address select: 0 = PC, 1 = ALUOut
ALUSrcA_o  out  2  00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB_o  out  2  00 = rs2, 01 = imm, 10 = 4
ResultSrc_o  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = imm
ALUControl_o  out  ALUCTRL_W  operation: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 7, sra 8, sltu 9
ImmSrc_o  out  3  I 000, S 001, B 010, J 011, U 100 (combinational from op_i)
illegal_o  out  1  sticky illegal-opcode flag

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Supported opcodes: lw, sw, R-type, I-type ALU, beq/bne, jal, jalr, lui, auipc.
- Moore control: all controls except PCWrite_o, IRWrite_o and ImmSrc_o are registered from the next-state decode, so they are valid in the cycle the FSM occupies that state.
- Reset: state <= Fetch; illegal_o <= 0; registered controls load the Fetch encoding; PCWrite_o, IRWrite_o, MemWrite_o and RegWrite_o are forced to 0 while reset is high.
- States (5-bit): Fetch, Decode, MemAdr, MemRead, MemWB, MemWrite, ExecR, ExecI, ALUWB, Branch, JAL, JALRAdr, JALRJump, LUI, Illegal.
- Fetch (AdrSrc 0, A = PC, B = 4, ResultSrc 10, add):
  - PCWrite_o = IRWrite_o = mem_ready_i.
  - Go to Decode when mem_ready_i = 1; otherwise hold.
- Decode (A = OldPC, B = imm, add; ALUOut <= OldPC + imm). Next state by opcode:
  - lw/sw -> MemAdr
  - R-type -> ExecR
  - I-type ALU -> ExecI
  - branch -> Branch
  - jal -> JAL
  - jalr -> JALRAdr
  - lui -> LUI
  - auipc -> ALUWB (ALUOut already holds OldPC + imm)
  - any other opcode -> Illegal
- MemAdr (A = rs1, B = imm, add): -> MemRead (lw) or MemWrite (sw).
- MemRead (AdrSrc 1): hold until mem_ready_i, then -> MemWB.
- MemWB: RegWrite_o = 1, ResultSrc 01; -> Fetch.
- MemWrite (AdrSrc 1): MemWrite_o = 1 and held every cycle until mem_ready_i; -> Fetch on the ready cycle.
- ExecR / ExecI: A = rs1, B = rs2 (ExecR) or imm (ExecI); ALU op decoded from funct3/funct7 as below; -> ALUWB.
- ALU decode by funct3:
  - 000: sub only for R-type with funct7_i = 1, else add
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and
  - 101: sra if funct7_i = 1, else srl
- ALUWB: RegWrite_o = 1, ResultSrc 00; -> Fetch.
- Branch (A = rs1, B = rs2, sub, ResultSrc 00): -> Fetch.
  - PCWrite_o = zero_i for funct3 000 (beq); ~zero_i for funct3 001 (bne).
  - Any other funct3 -> Illegal.
- JAL: PCWrite_o = 1 (PC <= ALUOut); A = OldPC, B = 4, add; -> ALUWB.
- JALRAdr: A = rs1, B = imm, add; -> JALRJump.
- JALRJump: PCWrite_o = 1, ResultSrc 00; A = OldPC, B = 4, add; -> ALUWB.
- LUI: RegWrite_o = 1, ResultSrc 11; -> Fetch.
- Illegal: all enables 0; illegal_o = 1; state holds until reset.
- MEM_WAIT_EN = 0: every memory state lasts exactly one cycle. Latencies: lw 5 cycles, sw 4, R/I-type 4, branch 3, jal 4, jalr 5, lui 3, auipc 3.
- A drop of mem_ready_i never aborts an access. Reset asserted mid-instruction returns to Fetch on the next edge with no write strobe asserted.
- Undefined selector fields are driven 0, not x.

Test Plan:
- lw, mem_ready_i held 1 -> state sequence Fetch, Decode, MemAdr, MemRead, MemWB; RegWrite_o = 1 only in cycle 5, ResultSrc 01.
- sw with mem_ready_i low for 3 cycles in MemWrite -> MemWrite_o high 4 consecutive cycles; PCWrite_o = 0 throughout; then Fetch.
- R-type funct3 101, funct7 1 -> ALUControl_o = 8 in ExecR; same fields on an I-type (op 0010011) -> ALUControl_o = 8 (srai); funct3 000 with funct7 1 on an I-type -> 0 (add).
- bne with zero_i = 0 -> PCWrite_o = 1 in the Branch state; beq with zero_i = 0 -> PCWrite_o = 0.
- jalr -> JALRAdr, JALRJump (PCWrite_o = 1), ALUWB (RegWrite_o = 1): 5 cycles total.
- op_i = 0000000 in Decode -> illegal_o = 1 and held 10 cycles with no enables; reset pulse -> illegal_o = 0, Fetch; reset asserted during MemWrite -> MemWrite_o = 0 next cycle.
